// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
// ex_muldiv: iterative RV32M multiply/divide unit beside the execute stage.
// Operands are reduced to magnitudes on acceptance, an unsigned shift-add
// multiplier or restoring divider runs for XLEN/UNROLL cycles, and the sign
// is restored in a single FIX cycle before the one-cycle DONE result pulse.
//
// Handshake: start_i is a request, not a held valid. It is accepted only in
// IDLE with annul_i low; from then on the operands are never re-sampled and
// start_i is ignored until the unit is back in IDLE. ready_o is a single-cycle
// pulse with no back-pressure: result_o is valid in that cycle and keeps its
// value until the next result is written. stallreq_o covers every cycle from
// acceptance up to (not including) the ready_o cycle.
//
// UNROLL must be 1, 2 or 4 and must divide XLEN.
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            annul_i,
    output logic            stallreq_o,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'(N - 1);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    // funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;

    logic [2:0]        r_op;
    logic              r_neg_res;   // product / quotient must be negated
    logic              r_neg_rem;   // remainder must be negated (sign of dividend)
    logic [XLEN-1:0]   r_opb;       // multiplicand (mul) or divisor (div), magnitude
    logic [2*XLEN-1:0] r_acc;       // {hi, lo}: product, or {remainder, quotient}
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;
    logic              r_busy;
    logic              r_ready;

    // Acceptance-side decode
    logic              w_accept;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;

    // Iteration datapath
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem;
    logic [2*XLEN-1:0] w_acc_nx;

    // Sign fix-up
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rmd;
    logic [XLEN-1:0]   w_fix_res;

    assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;

    // Operand signedness, magnitudes and the divide fast-path detection
    always_comb begin
        w_a_signed = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                     (op_i == OP_DIV) || (op_i == OP_REM);
        w_b_signed = (op_i == OP_MUL) || (op_i == OP_MULH) ||
                     (op_i == OP_DIV) || (op_i == OP_REM);
        w_a_neg    = w_a_signed && rs1_i[XLEN-1];
        w_b_neg    = w_b_signed && rs2_i[XLEN-1];
        w_a_abs    = w_a_neg ? (~rs1_i + 1'b1) : rs1_i;
        w_b_abs    = w_b_neg ? (~rs2_i + 1'b1) : rs2_i;
        w_div0     = op_i[2] && (rs2_i == '0);
        w_ovf      = op_i[2] && !op_i[0] && (rs1_i == MIN_VAL) && (rs2_i == '1);
        w_fast     = w_div0 || w_ovf;
        w_fast_res = '0;
        if (w_div0) begin
            // x/0: quotient all ones, remainder is the raw dividend
            w_fast_res = op_i[1] ? rs1_i : '1;
        end else if (w_ovf) begin
            // MIN/-1: quotient wraps to MIN, remainder is zero
            w_fast_res = op_i[1] ? '0 : MIN_VAL;
        end
    end

    // UNROLL shift-add or restoring-division steps per CALC cycle
    always_comb begin
        w_hi  = r_acc[2*XLEN-1:XLEN];
        w_lo  = r_acc[XLEN-1:0];
        w_sum = '0;
        w_rem = '0;
        for (int k = 0; k < UNROLL; k++) begin
            if (!r_op[2]) begin
                // add multiplicand when the current multiplier bit is set, then shift right
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end else begin
                // shift next dividend bit into the partial remainder, subtract if it fits
                w_rem = {w_hi, w_lo[XLEN-1]};
                w_lo  = {w_lo[XLEN-2:0], 1'b0};
                if (w_rem >= {1'b0, r_opb}) begin
                    w_rem   = w_rem - {1'b0, r_opb};
                    w_lo[0] = 1'b1;
                end
                w_hi = w_rem[XLEN-1:0];
            end
        end
        w_acc_nx = {w_hi, w_lo};
    end

    // Sign correction and result selection used in FIX
    always_comb begin
        w_prod    = r_neg_res ? (~r_acc + 1'b1) : r_acc;
        w_quo     = r_neg_res ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rmd     = r_neg_rem ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        w_fix_res = '0;
        if (!r_op[2]) begin
            w_fix_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
        end else begin
            w_fix_res = r_op[1] ? w_rmd : w_quo;
        end
    end

    // Next-state logic; annul_i overrides every state
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (annul_i) begin
                    w_state_nx = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_nx = S_FIX;
                end
            end
            S_FIX: begin
                w_state_nx = annul_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // State register plus registered busy/ready flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_ready <= (w_state_nx == S_DONE);
        end
    end

    // Operand capture, iteration and result write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op      <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_opb     <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op      <= op_i;
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_cnt     <= '0;
                        if (!op_i[2]) begin
                            r_opb <= w_a_abs;
                            r_acc <= {{XLEN{1'b0}}, w_b_abs};
                        end else begin
                            r_opb <= w_b_abs;
                            r_acc <= {{XLEN{1'b0}}, w_a_abs};
                        end
                        if (w_fast) begin
                            r_result <= w_fast_res;
                        end
                    end
                end
                S_CALC: begin
                    if (!annul_i) begin
                        r_acc <= w_acc_nx;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_FIX: begin
                    if (!annul_i) begin
                        r_result <= w_fix_res;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign stallreq_o  = rst && (w_accept || (r_state == S_CALC) || (r_state == S_FIX));
    assign busy_o      = r_busy;
    assign ready_o     = r_ready;
    assign result_o    = r_result;
    assign dbg_state_o = r_state;

endmodule
